csla_seq_divider32: RTL
=======================

Name: csla_seq_divider32

Overview:
- Sequential 32-bit restoring divider. It is the inverse-direction companion to the Karatsuba multiplier datapath.
- Each cycle it performs one trial subtraction on a carry-select subtract stage, producing one quotient bit per cycle.
- It sits beside the multiplier as an arithmetic unit with a valid/ready request port and a valid/ready result port.

Parameters:
- WIDTH, 32, operand, quotient and remainder width. Only 32 is verified.
- CNT_W, 6, iteration counter width. Must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  request valid.
- in_ready  output  1  divider can accept a request. High only in IDLE.
- dividend  input  WIDTH  numerator. Sampled on accept.
- divisor  input  WIDTH  denominator. Sampled on accept.
- out_valid  output  1  result valid. High only in DONE.
- out_ready  input  1  consumer accepts result.
- quotient  output  WIDTH  result quotient.
- remainder  output  WIDTH  result remainder.
- div_by_zero  output  1  flag: the accepted divisor was 0.

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high.
- Reset values: state=IDLE, in_ready=1, out_valid=0, quotient=0, remainder=0, div_by_zero=0, counter=0.
- Reset mid-operation: rst aborts RUN or DONE. The in-flight result is discarded and never presented.
- FSM states: IDLE, RUN, DONE.
- IDLE -> RUN: on accept (in_valid && in_ready) with divisor != 0.
  - Latch D=divisor and Q=dividend; clear partial remainder R (WIDTH+1 bits); counter=WIDTH.
- IDLE -> DONE: on accept with divisor == 0.
  - quotient=all-ones, remainder=dividend, div_by_zero=1.
  - out_valid is high the cycle after accept.
- RUN, each cycle:
  - T = {R[WIDTH-1:0], Q[WIDTH-1]} - {1'b0, D}, computed on the subtract stage as A + ~B + 1.
  - No borrow: R<=T and Q<={Q[WIDTH-2:0],1}.
  - Borrow: R<={R[WIDTH-1:0],Q[WIDTH-1]} and Q<={Q[WIDTH-2:0],0}.
  - counter decrements each RUN cycle. When counter==1, go to DONE.
- DONE:
  - Present quotient=Q and remainder=R[WIDTH-1:0]. Outputs stay stable while out_ready=0.
  - On out_valid && out_ready, go to IDLE.
- Latency: accept in cycle N. out_valid rises in cycle N+WIDTH+1 (N+33). Divide-by-zero results rise in cycle N+1.
- Throughput: one operation in flight. in_ready=0 from the cycle after accept until the result handshake completes.
- Back-to-back: in_ready returns the cycle after the result handshake, so there is no same-cycle accept.
- Outputs hold their last values while in IDLE.
- Edge cases:
  - Dividend 0 -> quotient 0, remainder 0 after the full latency.
  - Divisor 1 -> quotient=dividend, remainder 0.

Optional Feature:
- Macro: CSLA_DIV_SIGNED_EN.
- Defined: operands are two's complement.
  - Magnitudes are taken on accept and the unsigned core runs unchanged.
  - The quotient is negated if the operand signs differ; it truncates toward zero.
  - The remainder takes the dividend's sign.
  - Sign fix-up costs one extra cycle, so latency is N+34.
  - 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0, div_by_zero=0.
  - Divide by zero: quotient all-ones, remainder=dividend.
- Undefined: unsigned only, and latency is exactly as above.

Decomposition:
- Package csla_div_pkg:
  - state enum {IDLE, RUN, DONE}.
  - constants DIV_WIDTH=32 and DIV_CNT_W=6.
  - divide-by-zero quotient constant DIV_Z_QUOT = all-ones.
- Sub-module csla_sub33: combinational (WIDTH+1)-bit subtract built from carry-select-with-BEC groups. Outputs difference and borrow. Instantiated once.

Test Plan:
- 100 / 7, out_ready=1 -> after 33 cycles quotient=14, remainder=2, div_by_zero=0; out_valid high exactly one cycle.
- 0x12345678 / 0 -> next cycle quotient=0xFFFFFFFF, remainder=0x12345678, div_by_zero=1.
- 0xFFFFFFFF / 0x00000001 -> quotient=0xFFFFFFFF, remainder=0. Then 0xFFFFFFFF / 0xFFFFFFFF -> quotient=1, remainder=0.
- 1000 / 3 with out_ready held low 10 cycles after out_valid -> quotient=333, remainder=1 held stable, in_ready=0 throughout. Release -> IDLE next cycle.
- Start 50/5, assert rst at iteration 12 -> out_valid never rises, in_ready=1 after reset. Then 9/4 -> quotient=2, remainder=1.
- CSLA_DIV_SIGNED_EN defined: -7 / 2 -> quotient=0xFFFFFFFD, remainder=0xFFFFFFFF, at cycle N+34.

Source files
------------

// File: rtl/csla_div_pkg.sv
// Shared types and constants for the sequential carry-select divider.
// CSLA_DIV_SIGNED_EN adds a sign fix-up state for two's complement operands.
package csla_div_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_CNT_W = 6;

    // Quotient reported when the divisor is zero.
    localparam logic [DIV_WIDTH-1:0] DIV_Z_QUOT = '1;

`ifdef CSLA_DIV_SIGNED_EN
    typedef enum logic [1:0] {IDLE, RUN, DONE, FIX} div_state_t;
`else
    typedef enum logic [1:0] {IDLE, RUN, DONE} div_state_t;
`endif

    // Magnitude of a two's complement value.
    // The most negative value maps to itself, which is its correct unsigned magnitude.
    function automatic logic [DIV_WIDTH-1:0] div_mag(input logic [DIV_WIDTH-1:0] v);
        return v[DIV_WIDTH-1] ? -v : v;
    endfunction

endpackage

// File: rtl/csla_div_sub.sv
// Combinational W-bit subtract a - b = a + ~b + 1 built from carry-select groups.
// Each group forms its sum once and derives the carry-in=1 version with an
// excess-1 (increment) converter, then selects on the incoming group carry.
module csla_sub33 #(
    parameter int W  = 33,
    parameter int GW = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] diff,
    output logic         borrow
);
    // Padding is always at least one bit so the carry out of bit W-1 lands in sum_ext[W].
    localparam int NG = W / GW + 1;
    localparam int EW = NG * GW;

    logic [EW-1:0] a_ext;
    logic [EW-1:0] nb_ext;
    logic [EW-1:0] sum_ext;
    logic [NG:0]   carry;

    assign a_ext    = {{(EW-W){1'b0}}, a};
    assign nb_ext   = {{(EW-W){1'b0}}, ~b};
    assign carry[0] = 1'b1;

    for (genvar g = 0; g < NG; g++) begin : g_grp
        logic [GW:0] sum0;
        logic [GW:0] sum1;
        assign sum0 = {1'b0, a_ext[g*GW +: GW]} + {1'b0, nb_ext[g*GW +: GW]};
        assign sum1 = sum0 + (GW+1)'(1);
        assign {carry[g+1], sum_ext[g*GW +: GW]} = carry[g] ? sum1 : sum0;
    end

    assign diff   = sum_ext[W-1:0];
    // Carry out of the top bit set means a >= b; its absence is the borrow.
    assign borrow = ~sum_ext[W];

    logic unused_pad;
    assign unused_pad = ^{sum_ext[EW-1:W+1], carry[NG]};

endmodule

// File: rtl/csla_seq_divider32.sv
// Sequential restoring divider: one quotient bit per cycle through csla_sub33.
// Optional macro CSLA_DIV_SIGNED_EN: two's complement operands, one extra
// fix-up cycle before the result is presented.
module csla_seq_divider32
    import csla_div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int CNT_W = DIV_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);
    div_state_t       state, state_next;
    logic [WIDTH:0]   rem_acc;
    logic [WIDTH-1:0] quo_acc;
    logic [WIDTH-1:0] dvsr;
    logic [CNT_W-1:0] count;

    logic             accept;
    logic [WIDTH:0]   trial_a;
    logic [WIDTH:0]   trial_d;
    logic             borrow;
    logic [WIDTH:0]   rem_step;
    logic [WIDTH-1:0] quo_step;
    logic [WIDTH-1:0] dividend_mag;
    logic [WIDTH-1:0] divisor_mag;

    assign accept = in_valid && in_ready;

`ifdef CSLA_DIV_SIGNED_EN
    logic neg_q;
    logic neg_r;
    assign dividend_mag = div_mag(dividend);
    assign divisor_mag  = div_mag(divisor);
`else
    assign dividend_mag = dividend;
    assign divisor_mag  = divisor;
`endif

    // Trial subtraction of the shifted partial remainder against the divisor.
    assign trial_a = {rem_acc[WIDTH-1:0], quo_acc[WIDTH-1]};

    csla_sub33 #(.W(WIDTH+1)) u_sub (
        .a      (trial_a),
        .b      ({1'b0, dvsr}),
        .diff   (trial_d),
        .borrow (borrow)
    );

    assign rem_step = borrow ? trial_a : trial_d;
    assign quo_step = {quo_acc[WIDTH-2:0], ~borrow};

    // The partial remainder never exceeds the divisor, so its top bit is never consumed.
    logic unused_rem_msb;
    assign unused_rem_msb = rem_acc[WIDTH];

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state and handshake outputs.
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (accept) state_next = (divisor == '0) ? DONE : RUN;
            end
            RUN: begin
`ifdef CSLA_DIV_SIGNED_EN
                if (count == CNT_W'(1)) state_next = FIX;
`else
                if (count == CNT_W'(1)) state_next = DONE;
`endif
            end
`ifdef CSLA_DIV_SIGNED_EN
            FIX: state_next = DONE;
`endif
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Operand capture, iteration datapath and result registers.
    // NOTE: the datapath registers are few and all reset, so reset leaves no stale result visible.
    always_ff @(posedge clk) begin
        if (rst) begin
            rem_acc     <= '0;
            quo_acc     <= '0;
            dvsr        <= '0;
            count       <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
`ifdef CSLA_DIV_SIGNED_EN
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (divisor == '0) begin
                            quotient    <= DIV_Z_QUOT;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                        end else begin
                            dvsr        <= divisor_mag;
                            quo_acc     <= dividend_mag;
                            rem_acc     <= '0;
                            count       <= CNT_W'(WIDTH);
                            div_by_zero <= 1'b0;
`ifdef CSLA_DIV_SIGNED_EN
                            neg_q       <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                            neg_r       <= dividend[WIDTH-1];
`endif
                        end
                    end
                end
                RUN: begin
                    rem_acc <= rem_step;
                    quo_acc <= quo_step;
                    count   <= count - CNT_W'(1);
`ifndef CSLA_DIV_SIGNED_EN
                    if (count == CNT_W'(1)) begin
                        quotient  <= quo_step;
                        remainder <= rem_step[WIDTH-1:0];
                    end
`endif
                end
`ifdef CSLA_DIV_SIGNED_EN
                FIX: begin
                    quotient  <= neg_q ? -quo_acc : quo_acc;
                    remainder <= neg_r ? -rem_acc[WIDTH-1:0] : rem_acc[WIDTH-1:0];
                end
`endif
                default: ;
            endcase
        end
    end

endmodule
